mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Parameterised multi-cycle multiply/divide unit that replaces the fixed 32-bit shift-add multiplier inside the ALU.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and produces a 2*WIDTH result split into hi/lo.
- Uses a start/busy/done handshake with the control FSM.
- hi/lo feed the HI/LO registers and the ALUOut mux, as the current mul result does.

Parameters:
WIDTH, 32, operand width in bits (≥4); internal counter width is clog2(WIDTH+1)

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
oper_A  in  WIDTH  multiplicand / dividend; sampled with start
oper_B  in  WIDTH  multiplier / divisor; sampled with start
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
div_zero  out  1  last division had divisor 0; valid from done
hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient
count  out  clog2(WIDTH+1)  iterations remaining (debug, replaces MultCounter)

Behaviour:
- Reset (reset=0, asynchronous, any state including mid-operation):
  - state=IDLE; busy, done, div_zero, hi, lo, count all 0.
  - An in-flight operation is discarded, no done.
- States: IDLE, RUN, FIX.
- IDLE:
  - On the edge where start=1, capture op and operand magnitudes; set sign flags (signed ops only).
  - Set count=WIDTH and go to RUN, with busy=1 from the next cycle.
  - Signed ops take the magnitude of each operand first; |MIN| is MIN read as unsigned.
- RUN, one iteration per edge, count decrements:
  - MULT: restoring shift-add on the unsigned magnitudes.
  - DIV: restoring shift-subtract, one quotient bit per edge.
  - At count 1→0, go to FIX.
- FIX, single edge:
  - Apply signs to the result.
  - Product is negated if sign_A xor sign_B.
  - Quotient is negated if sign_A xor sign_B; remainder takes the sign of the dividend (truncate toward zero).
  - Load hi/lo, pulse done=1 for exactly one cycle, clear busy, return to IDLE.
- Latency: done is high in the cycle after edge WIDTH+2, counting the start edge as edge 1.
- hi/lo/div_zero hold their values until the next done; they never change while busy.
- Divide by zero (DIV/DIVU with oper_B=0):
  - Detected at the start edge; RUN is skipped and the unit goes directly to FIX.
  - Result: hi=oper_A (raw), lo=all ones, div_zero=1. done comes 2 edges after start.
  - div_zero is cleared at the done of any other operation.
- Signed overflow DIV MIN/−1: lo=MIN, hi=0, div_zero=0 (natural wrap of the magnitude algorithm).
- start while busy or in the done cycle's edge (FIX→IDLE edge): ignored, no queueing.
- start and op change after the capture edge have no effect on the running operation.
- Arithmetic is modulo 2*WIDTH for products; no flags other than div_zero.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined (MULT/MULTU only):
  - RUN exits to FIX as soon as the remaining unshifted multiplier magnitude is zero.
  - If |oper_B|=0 at start, RUN is skipped entirely.
  - done comes at edge 2+bitlength(|oper_B|).
  - Results are identical to the fixed-latency case.
- Undefined: multiply latency is fixed at WIDTH+2.
- Division is always fixed-latency regardless of the macro.

Test Plan:
- WIDTH=32, MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly at edge 34, busy high edges 2–33.
- MULT 0xFFFFFFFD(−3)×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9(−7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → div_zero=1, hi=5, lo=0xFFFFFFFF, done at edge 2. A following MULTU 2×3 clears div_zero, lo=6.
- Pulse start with new operands at edge 10 of a running MULT → ignored, result unchanged. Assert reset low at edge 20 of a DIV → all outputs 0 immediately, no done, next start works normally.
- MULDIV_EARLY_EXIT_EN defined: MULTU 5×3 → lo=15, done at edge 4; MULTU 9×0 → lo=0, done at edge 2. Undefined: both done at edge 34.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply and divide with a start/busy/done handshake.
// Optional early exit for multiplies: define MULDIV_EARLY_EXIT_EN.
module mul_div_unit #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                 r_state;
    logic                   r_busy, r_done, r_div_zero, r_dz, r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]       r_hi, r_lo, r_mplier;
    logic [2*WIDTH-1:0]     r_acc, r_mcand;
    logic [CW-1:0]          r_count;

    logic                   w_signed, w_dz_in, w_skip, w_last;
    logic [WIDTH-1:0]       w_mag_a, w_mag_b, w_mplier_nx, w_quot, w_rem;
    logic [WIDTH:0]         w_trial;
    logic [2*WIDTH-1:0]     w_add, w_prod;

    assign w_signed    = ~op[0];
    assign w_mag_a     = (w_signed && oper_A[WIDTH-1]) ? -oper_A : oper_A;
    assign w_mag_b     = (w_signed && oper_B[WIDTH-1]) ? -oper_B : oper_B;
    assign w_dz_in     = op[1] && (oper_B == '0);

    assign w_add       = r_acc + r_mcand;
    assign w_mplier_nx = r_mplier >> 1;
    // r_acc holds {remainder, dividend/quotient}; the trial subtract sees the remainder shifted in one bit
    assign w_trial     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mcand[WIDTH-1:0]};

    assign w_prod      = r_neg_q ? -r_acc : r_acc;
    assign w_quot      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_EXIT_EN
    assign w_skip = w_dz_in || (!op[1] && (w_mag_b == '0));
    assign w_last = (r_count == CW'(1)) || (!r_is_div && (w_mplier_nx == '0));
`else
    assign w_skip = w_dz_in;
    assign w_last = (r_count == CW'(1));
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_dz       <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_count    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_is_div <= op[1];
                        r_dz     <= w_dz_in;
                        r_state  <= w_skip ? S_FIX : S_RUN;
                        r_count  <= w_skip ? '0 : CW'(WIDTH);
                        r_mplier <= w_mag_b;
                        if (w_dz_in) begin
                            // Unsigned fix-up of {A, all-ones} yields hi=A, lo=all-ones
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_acc   <= {oper_A, {WIDTH{1'b1}}};
                            r_mcand <= '0;
                        end else begin
                            r_neg_q <= w_signed && (oper_A[WIDTH-1] ^ oper_B[WIDTH-1]);
                            r_neg_r <= w_signed && oper_A[WIDTH-1];
                            r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
                            r_mcand <= {{WIDTH{1'b0}}, op[1] ? w_mag_b : w_mag_a};
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count - CW'(1);
                    if (r_is_div) begin
                        r_acc <= w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                                : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end else begin
                        if (r_mplier[0]) r_acc <= w_add;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_nx;
                    end
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    {r_hi, r_lo} <= r_is_div ? {w_rem, w_quot} : w_prod;
                    r_div_zero   <= r_dz;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_count      <= '0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign count    = r_count;

endmodule
